// File: rtl/ivector_driver.sv
// Method-channel exerciser: issues a numbered stream of say requests round-robin
// across NUM_METH channels and checks the in-order heard responses on each channel.
module ivector_driver #(
  parameter int NUM_METH = 10,
  parameter int MAX_OUT  = 16,
  parameter int TIMEOUT  = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start__ENA,
  input  logic [31:0] start_count,
  input  logic [31:0] start_seed,
  output logic        start__RDY,
  output logic        say__ENA,
  output logic [31:0] say_meth,
  output logic [31:0] say_v,
  input  logic        say__RDY,
  input  logic        heard__ENA,
  input  logic [31:0] heard_meth,
  input  logic [31:0] heard_v,
  output logic        heard__RDY,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] err_count,
  output logic [31:0] rx_count
);

  localparam int MW = (NUM_METH > 1) ? $clog2(NUM_METH) : 1;
  localparam int MD = 1 << MW;
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [MW-1:0] M_LAST  = MW'(NUM_METH - 1);
  localparam logic [OW-1:0] OUT_CAP = OW'(MAX_OUT);
  localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT);
  localparam logic [31:0]   NM32    = 32'(NUM_METH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [31:0]     count_r;
  logic [31:0]     seed_r;
  logic [31:0]     k_r;
  logic [31:0]     rx_r;
  logic [MW-1:0]   m_r;
  logic [OW-1:0]   out_r;
  logic [TW-1:0]   idle_r;
  logic [TW-1:0]   idle_nxt_s;
  logic [15:0]     err_r;
  logic            timeout_r;
  // Arrays are padded to a power of two so any low-bit index stays in range.
  logic [31:0]     icnt_r [MD];
  logic [31:0]     rcnt_r [MD];

  logic            start_acc_s;
  logic            xfer_s;
  logic            acc_s;
  logic            resp_ok_s;
  logic            mismatch_s;
  logic            err_inc_s;
  logic            last_s;
  logic            tmo_hit_s;
  logic [MW-1:0]   hm_s;
  logic [31:0]     exp_s;

  // Handshake decode and response classification
  always_comb begin
    start_acc_s = start__ENA && start__RDY;
    xfer_s      = say__ENA && say__RDY;
    acc_s       = heard__ENA && heard__RDY;
    last_s      = (k_r == (count_r - 32'd1));
    hm_s        = heard_meth[MW-1:0];
    exp_s       = seed_r + 32'(hm_s) + (NM32 * rcnt_r[hm_s]);
    resp_ok_s   = acc_s && ((state_r == ISSUE) || (state_r == DRAIN)) &&
                  (heard_meth < NM32) && (rcnt_r[hm_s] < icnt_r[hm_s]);
    mismatch_s  = (heard_v != exp_s);
    err_inc_s   = acc_s && (!resp_ok_s || mismatch_s);
    if (state_r == DRAIN) begin
      if (acc_s) begin
        idle_nxt_s = {TW{1'b0}};
      end else begin
        idle_nxt_s = idle_r + TW'(1);
      end
    end else begin
      idle_nxt_s = idle_r;
    end
    tmo_hit_s = (state_r == DRAIN) && (out_r != {OW{1'b0}}) && (idle_nxt_s == TMO_LIM);
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (start_acc_s) begin
          state_nxt_s = (start_count == 32'd0) ? DONE : ISSUE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ISSUE: begin
        if (xfer_s && last_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      DRAIN: begin
        if ((out_r == {OW{1'b0}}) || tmo_hit_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Run datapath: issue index, per-channel counters, error and timeout tracking
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_r   <= 32'd0;
      seed_r    <= 32'd0;
      k_r       <= 32'd0;
      m_r       <= {MW{1'b0}};
      out_r     <= {OW{1'b0}};
      idle_r    <= {TW{1'b0}};
      err_r     <= 16'd0;
      rx_r      <= 32'd0;
      timeout_r <= 1'b0;
      for (int i = 0; i < MD; i++) begin
        icnt_r[i] <= 32'd0;
        rcnt_r[i] <= 32'd0;
      end
    end else if (start_acc_s) begin
      count_r   <= start_count;
      seed_r    <= start_seed;
      k_r       <= 32'd0;
      m_r       <= {MW{1'b0}};
      out_r     <= {OW{1'b0}};
      idle_r    <= {TW{1'b0}};
      err_r     <= 16'd0;
      rx_r      <= 32'd0;
      timeout_r <= 1'b0;
      for (int i = 0; i < MD; i++) begin
        icnt_r[i] <= 32'd0;
        rcnt_r[i] <= 32'd0;
      end
    end else begin
      if (xfer_s) begin
        k_r         <= k_r + 32'd1;
        m_r         <= (m_r == M_LAST) ? {MW{1'b0}} : (m_r + MW'(1));
        icnt_r[m_r] <= icnt_r[m_r] + 32'd1;
      end
      if (resp_ok_s) begin
        rcnt_r[hm_s] <= rcnt_r[hm_s] + 32'd1;
        rx_r         <= rx_r + 32'd1;
      end
      if (err_inc_s && (err_r != 16'hFFFF)) begin
        err_r <= err_r + 16'd1;
      end
      if (xfer_s && !resp_ok_s) begin
        out_r <= out_r + OW'(1);
      end else if (!xfer_s && resp_ok_s) begin
        out_r <= out_r - OW'(1);
      end
      idle_r <= idle_nxt_s;
      if (tmo_hit_s) begin
        timeout_r <= 1'b1;
      end
    end
  end

  // Output decode from registered state
  always_comb begin
    start__RDY = (state_r == IDLE) || (state_r == DONE);
    say__ENA   = (state_r == ISSUE) && (out_r < OUT_CAP);
    say_meth   = 32'(m_r);
    say_v      = seed_r + k_r;
    heard__RDY = !RST;
    done       = (state_r == DONE);
    pass       = (state_r == DONE) && (err_r == 16'd0) && !timeout_r;
    timeout    = timeout_r;
    err_count  = err_r;
    rx_count   = rx_r;
  end

endmodule

// File: tb/tb_ivector_driver.sv
// Directed bench for ivector_driver: table of runs against a loopback responder,
// plus hand sequences for outstanding cap, unexpected responses and mid-run reset.
module tb_ivector_driver;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start__ENA;
  logic [31:0] start_count;
  logic [31:0] start_seed;
  logic        start__RDY;
  logic        say__ENA;
  logic [31:0] say_meth;
  logic [31:0] say_v;
  logic        say__RDY;
  logic        heard__ENA;
  logic [31:0] heard_meth;
  logic [31:0] heard_v;
  logic        heard__RDY;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [15:0] err_count;
  logic [31:0] rx_count;

  int n_chk  = 0;
  int n_fail = 0;

  ivector_driver dut (
    .CLK(CLK), .RST(RST),
    .start__ENA(start__ENA), .start_count(start_count), .start_seed(start_seed),
    .start__RDY(start__RDY),
    .say__ENA(say__ENA), .say_meth(say_meth), .say_v(say_v), .say__RDY(say__RDY),
    .heard__ENA(heard__ENA), .heard_meth(heard_meth), .heard_v(heard_v),
    .heard__RDY(heard__RDY),
    .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .rx_count(rx_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] count;
    logic [31:0] seed;
    int          cor_meth;
    logic [31:0] cor_v;
    bit          drop_last;
    bit          toggle;
    bit          e_pass;
    bit          e_tmo;
    logic [15:0] e_err;
    logic [31:0] e_rx;
    int          e_cycles;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] cnt, input logic [31:0] seed);
    chk("start_rdy", {31'd0, start__RDY}, 32'd1);
    start__ENA  = 1'b1;
    start_count = cnt;
    start_seed  = seed;
    @(negedge CLK);
    start__ENA  = 1'b0;
  endtask

  task automatic pulse_resp(input logic [31:0] meth, input logic [31:0] v);
    heard__ENA = 1'b1;
    heard_meth = meth;
    heard_v    = v;
    @(negedge CLK);
    heard__ENA = 1'b0;
  endtask

  // One run with a 1-cycle loopback responder; checks every issued request.
  task automatic run_vec(input vec_t v, output int cycles, output int nxfer, output bit hit);
    logic        pend;
    logic [31:0] pm;
    logic [31:0] pv;
    logic [31:0] ev;
    int          pidx;
    pend = 1'b0; pm = 32'd0; pv = 32'd0; pidx = 0;
    cycles = 0; nxfer = 0; hit = 1'b0;
    while (cycles < 2000) begin
      if (done) begin
        hit = 1'b1;
        break;
      end
      heard__ENA = 1'b0;
      if (pend) begin
        if (!(v.drop_last && (pidx == int'(v.count) - 1))) begin
          heard__ENA = 1'b1;
          heard_meth = pm;
          heard_v    = (int'(pm) == v.cor_meth) ? v.cor_v : pv;
        end
        pend = 1'b0;
      end
      say__RDY = v.toggle ? cycles[0] : 1'b1;
      if (say__ENA && say__RDY) begin
        ev = v.seed + 32'(nxfer);
        chk("say_meth", say_meth, 32'(nxfer % 10));
        chk("say_v", say_v, ev);
        pend = 1'b1; pm = say_meth; pv = say_v; pidx = nxfer;
        nxfer++;
      end
      @(negedge CLK);
      cycles++;
    end
    heard__ENA = 1'b0;
    say__RDY   = 1'b0;
  endtask

  initial begin
    int  cyc;
    int  nx;
    bit  hit;

    tbl[0] = '{32'd20, 32'd100,        -1, 32'd0,  1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 32'd20, -1};
    tbl[1] = '{32'd0,  32'd55,         -1, 32'd0,  1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 32'd0,   0};
    tbl[2] = '{32'd10, 32'd0,           3, 32'd99, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 32'd10, -1};
    tbl[3] = '{32'd5,  32'd1000,       -1, 32'd0,  1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 32'd4,  1029};
    tbl[4] = '{32'd33, 32'hFFFF_FFF0,  -1, 32'd0,  1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 32'd33, -1};
    tbl[5] = '{32'd12, 32'd7,           0, 32'd5,  1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 32'd12, -1};

    RST = 1'b1; start__ENA = 1'b0; start_count = 32'd0; start_seed = 32'd0;
    say__RDY = 1'b0; heard__ENA = 1'b0; heard_meth = 32'd0; heard_v = 32'd0;
    repeat (3) @(negedge CLK);
    chk("rst_heard_rdy", {31'd0, heard__RDY}, 32'd0);
    chk("rst_say_ena", {31'd0, say__ENA}, 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    chk("idle_start_rdy", {31'd0, start__RDY}, 32'd1);
    chk("idle_heard_rdy", {31'd0, heard__RDY}, 32'd1);
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("idle_pass", {31'd0, pass}, 32'd0);
    chk("idle_err", {16'd0, err_count}, 32'd0);
    chk("idle_rx", rx_count, 32'd0);

    // Out-of-range meth while idle is unexpected
    pulse_resp(32'd12, 32'd0);
    chk("idle_meth12_err", {16'd0, err_count}, 32'd1);
    chk("idle_meth12_rx", rx_count, 32'd0);

    for (int i = 0; i < 6; i++) begin
      do_start(tbl[i].count, tbl[i].seed);
      run_vec(tbl[i], cyc, nx, hit);
      chk("run_done", {31'd0, hit}, 32'd1);
      chk("run_xfers", 32'(nx), tbl[i].count);
      chk("run_pass", {31'd0, pass}, {31'd0, tbl[i].e_pass});
      chk("run_timeout", {31'd0, timeout}, {31'd0, tbl[i].e_tmo});
      chk("run_err", {16'd0, err_count}, {16'd0, tbl[i].e_err});
      chk("run_rx", rx_count, tbl[i].e_rx);
      if (tbl[i].e_cycles >= 0) begin
        chk("run_cycles", 32'(cyc), 32'(tbl[i].e_cycles));
      end
    end

    // Response arriving in DONE is unexpected and leaves rx_count alone
    pulse_resp(32'd1, 32'd8);
    chk("done_resp_err", {16'd0, err_count}, 32'd3);
    chk("done_resp_rx", rx_count, 32'd12);
    chk("done_hold", {31'd0, done}, 32'd1);

    // Outstanding cap: no responses, so issue stalls at MAX_OUT
    do_start(32'd40, 32'd0);
    say__RDY = 1'b1;
    nx = 0;
    for (int c = 0; c < 30; c++) begin
      if (say__ENA && say__RDY) nx++;
      @(negedge CLK);
    end
    chk("cap_xfers", 32'(nx), 32'd16);
    chk("cap_say_ena", {31'd0, say__ENA}, 32'd0);
    chk("cap_done", {31'd0, done}, 32'd0);
    pulse_resp(32'd12, 32'd0);
    chk("cap_meth12_err", {16'd0, err_count}, 32'd1);
    chk("cap_meth12_rx", rx_count, 32'd0);
    pulse_resp(32'd0, 32'd0);
    chk("cap_resp_rx", rx_count, 32'd1);
    chk("cap_reopen", {31'd0, say__ENA}, 32'd1);

    // Reset mid-run abandons everything
    RST = 1'b1;
    @(negedge CLK);
    chk("mid_rst_heard_rdy", {31'd0, heard__RDY}, 32'd0);
    chk("mid_rst_say_ena", {31'd0, say__ENA}, 32'd0);
    chk("mid_rst_err", {16'd0, err_count}, 32'd0);
    chk("mid_rst_rx", rx_count, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_pass", {31'd0, pass}, 32'd0);
    chk("mid_rst_timeout", {31'd0, timeout}, 32'd0);
    chk("mid_rst_start_rdy", {31'd0, start__RDY}, 32'd1);
    RST = 1'b0;
    say__RDY = 1'b0;
    @(negedge CLK);
    chk("post_rst_heard_rdy", {31'd0, heard__RDY}, 32'd1);
    pulse_resp(32'd0, 32'd0);
    chk("post_rst_late_err", {16'd0, err_count}, 32'd1);
    chk("post_rst_late_rx", rx_count, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ivector_driver.md
IVECTOR_DRIVER -- requirements
Module: ivector_driver

Interface
REQ-001 SHALL have parameter NUM_METH, default 10, number of method channels; valid meth values are 0..NUM_METH-1.
REQ-002 SHALL have parameter MAX_OUT, default 16, cap on outstanding say requests.
REQ-003 SHALL have parameter TIMEOUT, default 1024, idle-cycle limit while draining.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 CLK  in  1  sole clock; all state updates on posedge.
REQ-006 RST  in  1  synchronous active-high reset.
REQ-007 start__ENA  in  1  begin a run; accepted only when start__RDY=1.
REQ-008 start$count  in  32  number of say requests to issue.
REQ-009 start$seed  in  32  base data value.
REQ-010 start__RDY  out  1  high in IDLE and DONE.
REQ-011 say__ENA  out  1  request valid; a transfer occurs when say__ENA and say__RDY are both 1.
REQ-012 say$meth  out  32  method index of the current request.
REQ-013 say$v  out  32  data of the current request.
REQ-014 say__RDY  in  1  responder can accept a request.
REQ-015 heard__ENA  in  1  response valid; accepted when heard__RDY=1.
REQ-016 heard$meth  in  32  method index of the response.
REQ-017 heard$v  in  32  data of the response.
REQ-018 heard__RDY  out  1  1 in every cycle RST=0; 0 while RST=1.
REQ-019 done  out  1  run complete.
REQ-020 pass  out  1  done and err_count==0 and timeout==0.
REQ-021 timeout  out  1  drain aborted by timeout.
REQ-022 err_count  out  16  mismatch/unexpected response count; saturates at 16'hFFFF.
REQ-023 rx_count  out  32  responses accepted in the current run.

Function
REQ-024 SHALL implement a state machine with states IDLE, ISSUE, DRAIN and DONE.
REQ-025 IDLE/DONE + start__ENA: latch count and seed, clear issue index k, per-meth receive counters rcnt[], outstanding, err_count, rx_count, timeout; next state ISSUE if count!=0, else DONE.
REQ-026 ISSUE: say__ENA=1 iff outstanding<MAX_OUT; say$meth = k mod NUM_METH; say$v = seed+k (mod 2^32).
REQ-027 A say transfer SHALL increment k and outstanding; after the transfer of k==count-1, next state DRAIN.
REQ-028 say__ENA SHALL be 0 outside ISSUE; say$meth/say$v SHALL be don't-care when say__ENA=0.
REQ-029 Accepted response: if meth<NUM_METH and rcnt[meth] < number of requests issued on that meth, expected = seed + meth + NUM_METH*rcnt[meth] (mod 2^32); on mismatch err_count+1; rcnt[meth]+1; outstanding-1; rx_count+1.
REQ-030 Responses SHALL be checked in order within a meth; ordering across meths is unconstrained.
REQ-031 Response with meth>=NUM_METH, on a meth with nothing outstanding, or received in IDLE/DONE: err_count+1; no other counter changes.
REQ-032 A say transfer and a response accepted in the same cycle SHALL leave outstanding unchanged.
REQ-033 DRAIN: when outstanding==0, next state DONE; an idle counter resets on every accepted response; if it reaches TIMEOUT, set timeout=1 and go to DONE.
REQ-034 done=1 only in DONE; err_count, rx_count and timeout hold until the next start.
REQ-035 A start in DONE SHALL restart exactly as from IDLE.

Reset
REQ-036 RST=1 SHALL force state IDLE and clear k, outstanding, rcnt[], err_count, rx_count, timeout and the idle counter; say__ENA=0, done=0, pass=0, heard__RDY=0.
REQ-037 RST asserted mid-run SHALL abandon the run; responses arriving after RST deasserts count as unexpected (REQ-031).

Verification
REQ-038 count=20, seed=100, loopback responder with 1-cycle delay -> meths 0..9,0..9, v=100..119; done, pass=1, rx_count=20.
REQ-039 count=0 -> DONE one cycle after start; pass=1; no say__ENA.
REQ-040 count=40, say__RDY=1, no responses -> exactly 16 transfers, then say__ENA stays 0 (MAX_OUT).
REQ-041 count=10, seed=0, responder corrupts meth 3 (v=99) -> err_count=1, pass=0.
REQ-042 count=5, responder drops the last response -> timeout=1 after 1024 idle cycles in DRAIN; rx_count=4.
REQ-043 Response with meth=12 while IDLE -> err_count=1; RST pulse mid-run -> all outputs cleared the next cycle.
